// File: rtl/uart_rx_deserializer.sv
// UART receive path: synchronizes the serial line, triple-samples each bit at
// mid-period and presents the received word with valid/parity/stop pulses.
`timescale 1ns/1ps
module uart_rx_deserializer #(
    parameter int DATAWIDTH = 8,
    parameter int PRESCALE  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rxIn,
    input  logic                 parEn,
    input  logic                 parType,
    output logic [DATAWIDTH-1:0] dataOut,
    output logic                 dataValid,
    output logic                 parErr,
    output logic                 stopErr
);

    localparam int EW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
    localparam int BW = (DATAWIDTH > 1) ? $clog2(DATAWIDTH) : 1;
    localparam logic [EW-1:0] SAMP0  = EW'(PRESCALE / 2 - 1);
    localparam logic [EW-1:0] SAMP1  = EW'(PRESCALE / 2);
    localparam logic [EW-1:0] DECIDE = EW'(PRESCALE / 2 + 1);
    localparam logic [EW-1:0] LAST   = EW'(PRESCALE - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATAWIDTH - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                 state_reg;
    logic                   sync_reg;
    logic                   rx_s;
    logic                   rx_p;
    logic [EW-1:0]          edge_cnt_reg;
    logic [BW-1:0]          bit_cnt_reg;
    logic [DATAWIDTH-1:0]   shift_reg;
    logic [1:0]             samp_reg;
    logic                   par_en_reg;
    logic                   par_type_reg;
    logic                   par_mis_reg;
    logic [DATAWIDTH-1:0]   data_out_reg;
    logic                   data_valid_reg;
    logic                   par_err_reg;
    logic                   stop_err_reg;

    logic maj;
    logic decide;
    logic bit_end;

    // Two early samples are held; the third is the live rx_s on the decision cycle.
    assign maj     = (samp_reg[0] & samp_reg[1]) | (samp_reg[0] & rx_s) | (samp_reg[1] & rx_s);
    assign decide  = (edge_cnt_reg == DECIDE);
    assign bit_end = (edge_cnt_reg == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            sync_reg       <= 1'b1;
            rx_s           <= 1'b1;
            rx_p           <= 1'b1;
            edge_cnt_reg   <= '0;
            bit_cnt_reg    <= '0;
            shift_reg      <= '0;
            samp_reg       <= '0;
            par_en_reg     <= 1'b0;
            par_type_reg   <= 1'b0;
            par_mis_reg    <= 1'b0;
            data_out_reg   <= '0;
            data_valid_reg <= 1'b0;
            par_err_reg    <= 1'b0;
            stop_err_reg   <= 1'b0;
        end else begin
            sync_reg       <= rxIn;
            rx_s           <= sync_reg;
            rx_p           <= rx_s;
            data_valid_reg <= 1'b0;
            par_err_reg    <= 1'b0;
            stop_err_reg   <= 1'b0;

            if (state_reg != IDLE) begin
                edge_cnt_reg <= bit_end ? '0 : edge_cnt_reg + 1'b1;
                if (edge_cnt_reg == SAMP0) samp_reg[0] <= rx_s;
                if (edge_cnt_reg == SAMP1) samp_reg[1] <= rx_s;
            end

            case (state_reg)
                IDLE: begin
                    // Needs a high-to-low transition, so a held-low line never re-arms.
                    if (rx_p && !rx_s) begin
                        state_reg    <= START;
                        edge_cnt_reg <= '0;
                        bit_cnt_reg  <= '0;
                        par_en_reg   <= parEn;
                        par_type_reg <= parType;
                        par_mis_reg  <= 1'b0;
                    end
                end
                START: begin
                    if (decide && maj) begin
                        state_reg    <= IDLE;
                        edge_cnt_reg <= '0;
                    end else if (bit_end) begin
                        state_reg <= DATA;
                    end
                end
                DATA: begin
                    if (decide) shift_reg <= {maj, shift_reg[DATAWIDTH-1:1]};
                    if (bit_end) begin
                        if (bit_cnt_reg == LAST_BIT) begin
                            bit_cnt_reg <= '0;
                            state_reg   <= par_en_reg ? PARITY : STOP;
                        end else begin
                            bit_cnt_reg <= bit_cnt_reg + 1'b1;
                        end
                    end
                end
                PARITY: begin
                    if (decide) par_mis_reg <= maj ^ (^shift_reg) ^ par_type_reg;
                    if (bit_end) state_reg <= STOP;
                end
                STOP: begin
                    // Leave mid-stop-bit so a back-to-back start edge is not missed.
                    if (decide) begin
                        state_reg    <= IDLE;
                        edge_cnt_reg <= '0;
                        if (!maj) begin
                            stop_err_reg <= 1'b1;
                        end else if (par_mis_reg) begin
                            par_err_reg <= 1'b1;
                        end else begin
                            data_out_reg   <= shift_reg;
                            data_valid_reg <= 1'b1;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign dataOut   = data_out_reg;
    assign dataValid = data_valid_reg;
    assign parErr    = par_err_reg;
    assign stopErr   = stop_err_reg;

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Bench for uart_rx_deserializer: frame-level outcome model plus per-cycle output compare.
`timescale 1ns/1ps
module tb_uart_rx_deserializer;

    localparam int DW = 8;
    localparam int P  = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          rxIn;
    logic          parEn;
    logic          parType;
    logic [DW-1:0] dataOut;
    logic          dataValid;
    logic          parErr;
    logic          stopErr;

    uart_rx_deserializer #(.DATAWIDTH(DW), .PRESCALE(P)) dut (
        .clk      (clk),
        .rst      (rst),
        .rxIn     (rxIn),
        .parEn    (parEn),
        .parType  (parType),
        .dataOut  (dataOut),
        .dataValid(dataValid),
        .parErr   (parErr),
        .stopErr  (stopErr)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        int          kind;   // 0 valid, 1 parity error, 2 stop error
        logic [7:0]  data;
    } ev_t;

    ev_t         exp_q[$];
    int          valid_cycs[$];
    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;
    int          n_valid = 0;
    int          n_par = 0;
    int          n_stop = 0;
    int          last_valid_cyc = 0;
    logic [7:0]  model_data = '0;
    logic        exp_valid;
    logic        exp_par;
    logic        exp_stop;
    ev_t         ev;

    always @(posedge clk) cyc <= cyc + 1;

    // Per-cycle compare against the expected-event queue.
    always @(negedge clk) begin
        exp_valid = 1'b0;
        exp_par   = 1'b0;
        exp_stop  = 1'b0;
        if (rst) begin
            exp_q.delete();
            model_data = '0;
        end else begin
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL missed_event: cycle %0d kind %0d still pending at cycle %0d",
                         exp_q[0].cyc, exp_q[0].kind, cyc);
                exp_q.delete(0);
            end
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                ev = exp_q.pop_front();
                case (ev.kind)
                    0: begin exp_valid = 1'b1; model_data = ev.data; end
                    1: exp_par = 1'b1;
                    default: exp_stop = 1'b1;
                endcase
            end
        end
        checks++;
        if ({dataValid, parErr, stopErr, dataOut} !== {exp_valid, exp_par, exp_stop, model_data}) begin
            errors++;
            $display("FAIL cycle_outputs @%0d: got v=%b p=%b s=%b d=%02h expected v=%b p=%b s=%b d=%02h",
                     cyc, dataValid, parErr, stopErr, dataOut, exp_valid, exp_par, exp_stop, model_data);
        end
        if (dataValid === 1'b1) begin
            n_valid++;
            last_valid_cyc = cyc;
            valid_cycs.push_back(cyc);
            $display("valid   @%0d data=%02h", cyc, dataOut);
        end
        if (parErr === 1'b1) begin
            n_par++;
            $display("parErr  @%0d", cyc);
        end
        if (stopErr === 1'b1) begin
            n_stop++;
            $display("stopErr @%0d", cyc);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic hold(input logic v, input int n);
        rxIn = v;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drives one frame; flip_par corrupts the parity bit, rst_bit pulses reset inside that data bit.
    task automatic send_frame(input logic [7:0] d, input logic pe, input logic pt,
                              input logic flip_par, input logic stop_bit, input int rst_bit);
        int   nb;
        int   start_cyc;
        logic pbit;
        int   kind;
        parEn     = pe;
        parType   = pt;
        start_cyc = cyc;
        pbit      = (^d) ^ pt ^ flip_par;
        nb        = 1 + DW + (pe ? 1 : 0);
        if (!stop_bit)                        kind = 2;
        else if (pe && (pbit != ((^d) ^ pt))) kind = 1;
        else                                  kind = 0;
        exp_q.push_back('{cyc: start_cyc + 3 + nb * P + P / 2 + 2, kind: kind, data: d});
        $display("frame   @%0d data=%02h parEn=%b parType=%b pbit=%b stop=%b kind=%0d",
                 start_cyc, d, pe, pt, pbit, stop_bit, kind);
        hold(1'b0, P);
        parEn   = ~pe;
        parType = ~pt;
        for (int i = 0; i < DW; i++) begin
            if (i == rst_bit) begin
                hold(d[i], 2);
                rst = 1'b1;
                hold(d[i], 2);
                rst = 1'b0;
                hold(d[i], P - 4);
            end else begin
                hold(d[i], P);
            end
        end
        if (pe) hold(pbit, P);
        hold(stop_bit, P);
    endtask

    initial begin
        int s;
        rst     = 1'b1;
        rxIn    = 1'b1;
        parEn   = 1'b0;
        parType = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("reset_dataOut", 32'(dataOut), 32'h0);
        check("reset_pulses", {29'd0, dataValid, parErr, stopErr}, 32'h0);
        rst = 1'b0;
        hold(1'b1, 20);

        s = cyc;
        send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, -1);
        hold(1'b1, 16);
        check("a5_latency", 32'(last_valid_cyc - s), 32'd81);
        check("a5_data", 32'(dataOut), 32'hA5);
        check("a5_count", 32'(n_valid), 32'd1);

        s = cyc;
        send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, -1);
        hold(1'b1, 16);
        check("3c_par_latency", 32'(last_valid_cyc - s), 32'd89);
        check("3c_data", 32'(dataOut), 32'h3C);

        send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, -1);
        hold(1'b1, 16);
        check("3c_parerr_count", 32'(n_par), 32'd1);
        check("3c_parerr_hold", 32'(dataOut), 32'h3C);

        send_frame(8'h81, 1'b1, 1'b1, 1'b0, 1'b1, -1);
        hold(1'b1, 16);
        check("81_odd_data", 32'(dataOut), 32'h81);

        send_frame(8'h81, 1'b1, 1'b1, 1'b1, 1'b0, -1);
        hold(1'b1, 16);
        check("81_stoperr_count", 32'(n_stop), 32'd1);
        check("81_stop_over_par", 32'(n_par), 32'd1);
        check("81_stoperr_hold", 32'(dataOut), 32'h81);

        // Break: a frame of all zeros with a zero stop bit, then silence.
        parEn = 1'b0;
        s = cyc;
        exp_q.push_back('{cyc: s + 81, kind: 2, data: 8'h00});
        hold(1'b0, 30 * P);
        check("break_one_stoperr", 32'(n_stop), 32'd2);
        hold(1'b1, 40);
        check("break_no_rearm", 32'(n_stop + n_par), 32'd3);
        check("break_valid_count", 32'(n_valid), 32'd3);

        hold(1'b0, 2);
        hold(1'b1, 40);
        check("glitch_no_pulse", 32'(n_valid + n_par + n_stop), 32'd6);
        send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b1, -1);
        hold(1'b1, 16);
        check("55_data", 32'(dataOut), 32'h55);

        send_frame(8'h12, 1'b0, 1'b0, 1'b0, 1'b1, -1);
        send_frame(8'h34, 1'b0, 1'b0, 1'b0, 1'b1, -1);
        send_frame(8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 3);
        hold(1'b1, 24);
        check("rst_cleared_data", 32'(dataOut), 32'h0);
        check("rst_no_pulse", 32'(n_valid), 32'd6);

        send_frame(8'h77, 1'b0, 1'b0, 1'b0, 1'b1, -1);
        hold(1'b1, 20);
        check("77_data", 32'(dataOut), 32'h77);
        check("valid_total", 32'(valid_cycs.size()), 32'd7);
        if (valid_cycs.size() == 7)
            check("b2b_spacing", 32'(valid_cycs[5] - valid_cycs[4]), 32'd80);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
